ddr_bw_ctrl: RTL and testbench
==============================

DDR_BW_CTRL -- requirements
Module: ddr_bw_ctrl

Interface
REQ-001 Parameter ADDR_W, default 32, meaning DDR address width.
REQ-002 Parameter LEN_W, default 8, meaning per-transaction burst-length field width.
REQ-003 Parameter CNT_W, default 32, meaning width of the transaction and cycle counters.
REQ-004 Parameter IDLE_GUARD, default 2, meaning minimum WAIT cycles before the engine idle input is sampled.
REQ-005 The block SHALL have these ports:
  clk  in  1  clock
  rstn  in  1  reset, synchronous, active-low
  START_REG  in  1  asynchronous run request, level
  DDR_BASEADDR_REG  in  ADDR_W  base address
  MODE_REG  in  2  0=read, 1=write, 2=read+write pair, 3=illegal
  NTRANS_REG  in  CNT_W  transaction count
  STRIDE_REG  in  ADDR_W  address increment per transaction
  LEN_REG  in  LEN_W  bursts per transaction
  RSTART_REG  out  1  read engine start pulse
  RADDR_REG  out  ADDR_W  read address
  RLENGTH_REG  out  32  read length, zero-extended LEN
  RIDLE_REG  in  1  read engine idle
  WSTART_REG  out  1  write engine start pulse
  WADDR_REG  out  ADDR_W  write address
  WNBURST_REG  out  32  write burst count, zero-extended LEN
  WIDLE_REG  in  1  write engine idle
  CYCLES_REG  out  CNT_W  run cycle count
  DONE_CNT_REG  out  CNT_W  completed transactions
  BUSY_REG, DONE_REG, ERR_REG, ABORT_REG  out  1  status flags

Function
REQ-006 START_REG SHALL pass through a 2-flop synchronizer; start_s denotes its output.
REQ-007 The FSM SHALL use the states IDLE, ARM, ISSUE, WAIT, NEXT, DONE, and ERR.
REQ-008 IDLE SHALL go to ARM when start_s=1.
REQ-009 ARM SHALL latch MODE, NTRANS, STRIDE, LEN, and BASE into internal registers.
REQ-010 ARM SHALL clear the counters and ABORT_REG, and set the address accumulator to BASE.
REQ-011 ARM SHALL go to ERR if MODE=3, else to DONE if NTRANS=0, else to ISSUE.
REQ-012 ISSUE SHALL assert exactly one start pulse for one cycle, then go to WAIT:
  - RSTART_REG in mode 0 and in the read half of mode 2.
  - WSTART_REG in mode 1 and in the write half of mode 2.
REQ-013 RADDR_REG and WADDR_REG SHALL be registered and SHALL equal the accumulator while the pulse is high.
REQ-014 WAIT SHALL ignore the idle input for IDLE_GUARD cycles, then go to NEXT when the selected engine's idle input=1.
REQ-015 In mode 2, NEXT after the read half SHALL return to ISSUE for the write half at the same address, without counting.
REQ-016 Otherwise NEXT SHALL increment DONE_CNT_REG and add STRIDE to the accumulator, wrapping mod 2^ADDR_W.
REQ-017 After that update, NEXT SHALL go to DONE if the count equals NTRANS, else to ISSUE.
REQ-018 If start_s=0 in ISSUE, WAIT, or NEXT, the current transaction (including the write half in mode 2) SHALL complete.
REQ-019 After such an early completion the FSM SHALL go to DONE with ABORT_REG=1.
REQ-020 CYCLES_REG SHALL increment every cycle in ISSUE, WAIT, and NEXT, saturate at all-ones, and hold elsewhere.
REQ-021 BUSY_REG SHALL be 1 in ARM, ISSUE, WAIT, and NEXT.
REQ-022 DONE_REG SHALL be 1 in DONE; ERR_REG SHALL be 1 in ERR.
REQ-023 DONE and ERR SHALL return to IDLE when start_s=0.
REQ-024 CYCLES_REG, DONE_CNT_REG, and ABORT_REG SHALL hold after the return to IDLE until the next ARM.
REQ-025 Register inputs SHALL be ignored outside ARM; mid-run changes SHALL have no effect.
REQ-026 RLENGTH_REG and WNBURST_REG SHALL present the latched LEN, zero-extended to 32 bits.

Reset
REQ-027 While rstn=0 at a clk edge, the FSM SHALL enter IDLE.
REQ-028 While rstn=0 at a clk edge, all outputs, counters, the accumulator, and the synchronizer flops SHALL be 0.
REQ-029 Reset asserted mid-run SHALL abandon the run immediately, with no further start pulses.

Structure
REQ-030 The state enum and the MODE encodings SHALL live in package ddr_bw_pkg.
REQ-031 The START_REG synchronization SHALL be one instance of the existing synchronizer_n sub-module.

Verification
REQ-032 Mode 0, BASE=0x1000, STRIDE=0x40, LEN=8, NTRANS=3, idle high 5 cycles after each pulse -> three RSTART pulses at 0x1000/0x1040/0x1080, RLENGTH=8, DONE_CNT=3, DONE=1.
REQ-033 Mode 2, NTRANS=2, STRIDE=0x100 -> pulse order R@BASE, W@BASE, R@BASE+0x100, W@BASE+0x100; DONE_CNT=2.
REQ-034 MODE=3 -> ERR_REG=1 two cycles after ARM, no start pulses; ERR_REG clears when START_REG drops.
REQ-035 NTRANS=0 -> DONE with CYCLES_REG=0 and no pulses.
REQ-036 START_REG dropped during the second WAIT of NTRANS=10 -> that transaction completes, DONE_CNT=2, ABORT_REG=1.
REQ-037 BASE=0xFFFFFFC0, STRIDE=0x40, NTRANS=2 -> second address 0x00000000; rstn pulsed mid-WAIT -> all outputs 0 the next cycle.

Source files
------------

// File: rtl/ddr_bw_pkg.sv
// Shared types for the DDR bandwidth controller: FSM states, transfer modes
// and small sizing helpers.
package ddr_bw_pkg;

  // Controller sequencing states.
  typedef enum logic [2:0] {
    IDLE,
    ARM,
    ISSUE,
    WAIT,
    NEXT,
    DONE,
    ERR
  } state_e;

  // MODE_REG encodings; MODE_ILL is rejected at ARM time.
  typedef enum logic [1:0] {
    MODE_RD  = 2'd0,
    MODE_WR  = 2'd1,
    MODE_RW  = 2'd2,
    MODE_ILL = 2'd3
  } mode_e;

  // Depth of the START_REG synchronizer chain.
  localparam int SYNC_STAGES = 2;

  // Width of a counter that must reach 'guard' (never narrower than one bit).
  function automatic int guard_width(input int guard);
    return (guard < 1) ? 1 : $clog2(guard + 1);
  endfunction

endpackage

// File: rtl/ddr_bw_ctrl_if.sv
// Command/status handshake between the controller and the DDR read/write
// engines. The controller is the master; the engines are the slave side.
interface ddr_bw_ctrl_if #(
  parameter int ADDR_W = 32
);

  logic              RSTART_REG;
  logic [ADDR_W-1:0] RADDR_REG;
  logic [31:0]       RLENGTH_REG;
  logic              RIDLE_REG;

  logic              WSTART_REG;
  logic [ADDR_W-1:0] WADDR_REG;
  logic [31:0]       WNBURST_REG;
  logic              WIDLE_REG;

  modport master (
    output RSTART_REG, RADDR_REG, RLENGTH_REG,
    output WSTART_REG, WADDR_REG, WNBURST_REG,
    input  RIDLE_REG, WIDLE_REG
  );

  modport slave (
    input  RSTART_REG, RADDR_REG, RLENGTH_REG,
    input  WSTART_REG, WADDR_REG, WNBURST_REG,
    output RIDLE_REG, WIDLE_REG
  );

endinterface

// File: rtl/synchronizer_n.sv
// N-stage flop synchronizer for bringing level signals into the clk domain.
module synchronizer_n #(
  parameter int STAGES = 2,
  parameter int WIDTH  = 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_sync [STAGES];

  // Shift the input through the flop chain; clear the chain on reset.
  // NOTE: reset is only seen at a clk edge (synchronous), so it sits inside the
  // clocked branch and is not in the sensitivity list.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < STAGES; i++) r_sync[i] <= '0;
    end else begin
      // NOTE: non-blocking assignments make every stage take the old value of
      // its predecessor, which is what turns this loop into a shift chain.
      r_sync[0] <= i_d;
      for (int i = 1; i < STAGES; i++) r_sync[i] <= r_sync[i-1];
    end
  end

  assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/ddr_bw_ctrl.sv
// DDR bandwidth test controller: issues NTRANS read, write or read+write
// transactions to the DDR engines at BASE + k*STRIDE, counting completed
// transactions and busy cycles, with graceful abort when START_REG drops.
module ddr_bw_ctrl
  import ddr_bw_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int LEN_W      = 8,
  parameter int CNT_W      = 32,
  parameter int IDLE_GUARD = 2
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              START_REG,
  input  logic [ADDR_W-1:0] DDR_BASEADDR_REG,
  input  logic [1:0]        MODE_REG,
  input  logic [CNT_W-1:0]  NTRANS_REG,
  input  logic [ADDR_W-1:0] STRIDE_REG,
  input  logic [LEN_W-1:0]  LEN_REG,
  ddr_bw_ctrl_if.master     eng,
  output logic [CNT_W-1:0]  CYCLES_REG,
  output logic [CNT_W-1:0]  DONE_CNT_REG,
  output logic              BUSY_REG,
  output logic              DONE_REG,
  output logic              ERR_REG,
  output logic              ABORT_REG
);

  localparam int GUARD_W = guard_width(IDLE_GUARD);

  logic               w_start_s;
  logic               w_wr_sel;
  logic               w_idle_sel;
  logic               w_stop;
  logic [CNT_W-1:0]   w_done_cnt_inc;

  state_e             r_state;
  mode_e              r_mode;
  logic [CNT_W-1:0]   r_ntrans;
  logic [ADDR_W-1:0]  r_stride;
  logic [ADDR_W-1:0]  r_acc;
  logic [LEN_W-1:0]   r_len;
  logic               r_wr_half;
  logic               r_stop;
  logic [GUARD_W-1:0] r_guard;

  synchronizer_n #(
    .STAGES (SYNC_STAGES),
    .WIDTH  (1)
  ) u_start_sync (
    .clk  (clk),
    .rstn (rstn),
    .i_d  (START_REG),
    .o_q  (w_start_s)
  );

  // The write engine is in play for write mode and for the second half of a
  // read+write pair; everything else talks to the read engine.
  assign w_wr_sel       = (r_mode == MODE_WR) || ((r_mode == MODE_RW) && r_wr_half);
  assign w_idle_sel     = w_wr_sel ? eng.WIDLE_REG : eng.RIDLE_REG;
  assign w_stop         = r_stop | ~w_start_s;
  assign w_done_cnt_inc = DONE_CNT_REG + 1'b1;

  // Engine length fields always show the length latched at ARM.
  assign eng.RLENGTH_REG = 32'(r_len);
  assign eng.WNBURST_REG = 32'(r_len);

  // Controller FSM with its registered status flags, pulses and counters.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state          <= IDLE;
      r_mode           <= MODE_RD;
      r_ntrans         <= '0;
      r_stride         <= '0;
      r_acc            <= '0;
      r_len            <= '0;
      r_wr_half        <= 1'b0;
      r_stop           <= 1'b0;
      r_guard          <= '0;
      eng.RSTART_REG   <= 1'b0;
      eng.RADDR_REG    <= '0;
      eng.WSTART_REG   <= 1'b0;
      eng.WADDR_REG    <= '0;
      CYCLES_REG       <= '0;
      DONE_CNT_REG     <= '0;
      BUSY_REG         <= 1'b0;
      DONE_REG         <= 1'b0;
      ERR_REG          <= 1'b0;
      ABORT_REG        <= 1'b0;
    end else begin
      // Start pulses last a single cycle unless ISSUE raises one below.
      eng.RSTART_REG <= 1'b0;
      eng.WSTART_REG <= 1'b0;

      // Active-run bookkeeping: saturating cycle count and sticky stop request.
      if (r_state inside {ISSUE, WAIT, NEXT}) begin
        if (CYCLES_REG != '1) CYCLES_REG <= CYCLES_REG + 1'b1;
        if (!w_start_s)       r_stop     <= 1'b1;
      end

      case (r_state)
        IDLE: begin
          if (w_start_s) begin
            r_state  <= ARM;
            BUSY_REG <= 1'b1;
          end
        end

        ARM: begin
          r_mode       <= mode_e'(MODE_REG);
          r_ntrans     <= NTRANS_REG;
          r_stride     <= STRIDE_REG;
          r_len        <= LEN_REG;
          r_acc        <= DDR_BASEADDR_REG;
          r_wr_half    <= 1'b0;
          r_stop       <= 1'b0;
          CYCLES_REG   <= '0;
          DONE_CNT_REG <= '0;
          ABORT_REG    <= 1'b0;
          if (mode_e'(MODE_REG) == MODE_ILL) begin
            r_state  <= ERR;
            BUSY_REG <= 1'b0;
            ERR_REG  <= 1'b1;
          end else if (NTRANS_REG == '0) begin
            r_state  <= DONE;
            BUSY_REG <= 1'b0;
            DONE_REG <= 1'b1;
          end else begin
            r_state  <= ISSUE;
          end
        end

        ISSUE: begin
          if (w_wr_sel) begin
            eng.WSTART_REG <= 1'b1;
            eng.WADDR_REG  <= r_acc;
          end else begin
            eng.RSTART_REG <= 1'b1;
            eng.RADDR_REG  <= r_acc;
          end
          r_guard <= '0;
          r_state <= WAIT;
        end

        WAIT: begin
          // The engine's idle flag is stale until it has seen the pulse.
          if (r_guard != GUARD_W'(IDLE_GUARD)) begin
            r_guard <= r_guard + 1'b1;
          end else if (w_idle_sel) begin
            r_state <= NEXT;
          end
        end

        NEXT: begin
          if ((r_mode == MODE_RW) && !r_wr_half) begin
            // Write half of the pair always runs, even when stopping.
            r_wr_half <= 1'b1;
            r_state   <= ISSUE;
          end else begin
            r_wr_half    <= 1'b0;
            DONE_CNT_REG <= w_done_cnt_inc;
            r_acc        <= r_acc + r_stride;
            if (w_done_cnt_inc == r_ntrans) begin
              r_state  <= DONE;
              BUSY_REG <= 1'b0;
              DONE_REG <= 1'b1;
            end else if (w_stop) begin
              r_state   <= DONE;
              BUSY_REG  <= 1'b0;
              DONE_REG  <= 1'b1;
              ABORT_REG <= 1'b1;
            end else begin
              r_state <= ISSUE;
            end
          end
        end

        DONE: begin
          if (!w_start_s) begin
            r_state  <= IDLE;
            DONE_REG <= 1'b0;
          end
        end

        ERR: begin
          if (!w_start_s) begin
            r_state <= IDLE;
            ERR_REG <= 1'b0;
          end
        end

        default: begin
          r_state  <= IDLE;
          BUSY_REG <= 1'b0;
          DONE_REG <= 1'b0;
          ERR_REG  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ddr_bw_ctrl.sv
// Self-checking bench for ddr_bw_ctrl: directed table, abort/reset sequences
// and randomized runs compared with a transaction-level reference model.
module tb_ddr_bw_ctrl;

  localparam int ADDR_W     = 32;
  localparam int LEN_W      = 8;
  localparam int CNT_W      = 32;
  localparam int IDLE_GUARD = 2;

  typedef struct {
    logic [1:0]  mode;
    logic [31:0] base;
    logic [31:0] stride;
    logic [7:0]  len;
    logic [31:0] ntrans;
  } cfg_t;

  typedef struct {
    string tag;
    cfg_t  cfg;
    bit    exp_err;
    int    exp_cnt;
  } vec_t;

  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] len;
  } pulse_t;

  logic              clk;
  logic              rstn;
  logic              start;
  logic [31:0]       base;
  logic [1:0]        mode;
  logic [31:0]       ntrans;
  logic [31:0]       stride;
  logic [7:0]        len;
  logic [CNT_W-1:0]  cycles;
  logic [CNT_W-1:0]  done_cnt;
  logic              busy, done, err, abort;

  pulse_t got_q[$];
  pulse_t exp_q[$];
  int     eng_lat;
  int     n_checks;
  int     n_errors;

  ddr_bw_ctrl_if #(.ADDR_W(ADDR_W)) eng_if ();

  ddr_bw_ctrl #(
    .ADDR_W     (ADDR_W),
    .LEN_W      (LEN_W),
    .CNT_W      (CNT_W),
    .IDLE_GUARD (IDLE_GUARD)
  ) dut (
    .clk              (clk),
    .rstn             (rstn),
    .START_REG        (start),
    .DDR_BASEADDR_REG (base),
    .MODE_REG         (mode),
    .NTRANS_REG       (ntrans),
    .STRIDE_REG       (stride),
    .LEN_REG          (len),
    .eng              (eng_if),
    .CYCLES_REG       (cycles),
    .DONE_CNT_REG     (done_cnt),
    .BUSY_REG         (busy),
    .DONE_REG         (done),
    .ERR_REG          (err),
    .ABORT_REG        (abort)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Expected pulse stream: one transaction per address BASE + k*STRIDE, read
  // before write when both engines are used.
  function automatic void build_model(input cfg_t c, input int n_txn);
    exp_q.delete();
    for (int i = 0; i < n_txn; i++) begin
      logic [31:0] a;
      a = c.base + c.stride * 32'(i);
      if (c.mode != 2'd1) exp_q.push_back({1'b0, a, 32'(c.len)});
      if (c.mode != 2'd0) exp_q.push_back({1'b1, a, 32'(c.len)});
    end
  endfunction

  // Behavioural engines: log every pulse, drop idle for eng_lat cycles.
  initial begin
    int rc;
    int wc;
    rc = 0;
    wc = 0;
    eng_if.RIDLE_REG = 1'b1;
    eng_if.WIDLE_REG = 1'b1;
    forever begin
      @(negedge clk);
      if (rstn !== 1'b1) begin
        rc = 0;
        wc = 0;
        eng_if.RIDLE_REG = 1'b1;
        eng_if.WIDLE_REG = 1'b1;
      end else begin
        if (rc > 0) begin rc--; if (rc == 0) eng_if.RIDLE_REG = 1'b1; end
        if (wc > 0) begin wc--; if (wc == 0) eng_if.WIDLE_REG = 1'b1; end
        if (eng_if.RSTART_REG === 1'b1) begin
          got_q.push_back({1'b0, eng_if.RADDR_REG, eng_if.RLENGTH_REG});
          if (eng_lat > 0) begin eng_if.RIDLE_REG = 1'b0; rc = eng_lat; end
        end
        if (eng_if.WSTART_REG === 1'b1) begin
          got_q.push_back({1'b1, eng_if.WADDR_REG, eng_if.WNBURST_REG});
          if (eng_lat > 0) begin eng_if.WIDLE_REG = 1'b0; wc = eng_lat; end
        end
      end
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_flags"}, {eng_if.RSTART_REG, eng_if.WSTART_REG, busy, done, err, abort}, '0);
    check({tag, "_cycles"}, cycles, '0);
    check({tag, "_done_cnt"}, done_cnt, '0);
    check({tag, "_raddr"}, eng_if.RADDR_REG, '0);
    check({tag, "_waddr"}, eng_if.WADDR_REG, '0);
    check({tag, "_lengths"}, {eng_if.RLENGTH_REG, eng_if.WNBURST_REG}, '0);
  endtask

  task automatic apply_cfg(input cfg_t c);
    mode   = c.mode;
    base   = c.base;
    stride = c.stride;
    len    = c.len;
    ntrans = c.ntrans;
  endtask

  // One complete run: start, optional mid-run input scramble or early stop,
  // end-state and pulse-stream checks, then release and hold checks.
  task automatic run_case(input string tag, input cfg_t c, input bit exp_err,
                          input int exp_cnt, input bit exp_abort,
                          input int drop_at, input bit scramble);
    bit          seen;
    bit          cleared;
    logic [31:0] cyc_snap;
    logic [31:0] cnt_snap;
    apply_cfg(c);
    got_q.delete();
    start = 1'b1;
    seen  = 1'b0;
    for (int cyc = 0; cyc < 3000 && !seen; cyc++) begin
      tick();
      if (drop_at >= 0 && start && got_q.size() >= drop_at) start = 1'b0;
      if (scramble && cyc == 6) begin
        mode   = 2'($urandom);
        base   = $urandom;
        stride = $urandom;
        len    = 8'($urandom);
        ntrans = $urandom_range(0, 50);
      end
      if (done || err) seen = 1'b1;
    end
    check({tag, "_finished"}, seen, 1'b1);
    check({tag, "_done"}, done, !exp_err);
    check({tag, "_err"}, err, exp_err);
    check({tag, "_done_cnt"}, done_cnt, 32'(exp_cnt));
    check({tag, "_abort"}, abort, exp_abort);
    check({tag, "_rlength"}, eng_if.RLENGTH_REG, 32'(c.len));
    check({tag, "_wnburst"}, eng_if.WNBURST_REG, 32'(c.len));
    if (exp_cnt == 0) check({tag, "_cycles_zero"}, cycles, '0);
    else              check({tag, "_cycles_nonzero"}, cycles != '0, 1'b1);
    build_model(c, exp_cnt);
    check({tag, "_npulses"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("%s_pulse%0d", tag, i), got_q[i], exp_q[i]);
    cyc_snap = cycles;
    cnt_snap = done_cnt;
    start    = 1'b0;
    cleared  = 1'b0;
    for (int cyc = 0; cyc < 20 && !cleared; cyc++) begin
      if (!done && !err) cleared = 1'b1;
      else tick();
    end
    check({tag, "_status_cleared"}, {cleared, busy, done, err}, 4'b1000);
    repeat (3) tick();
    check({tag, "_hold"}, {cycles, done_cnt, abort}, {cyc_snap, cnt_snap, exp_abort});
  endtask

  vec_t vecs[7];

  initial begin
    cfg_t c;
    int   n_seen;
    bit   ok;
    n_checks = 0;
    n_errors = 0;
    eng_lat  = 5;
    rstn     = 1'b0;
    start    = 1'b0;
    mode     = '0;
    base     = '0;
    stride   = '0;
    len      = '0;
    ntrans   = '0;

    vecs[0] = '{"mode0_basic",  '{2'd0, 32'h0000_1000, 32'h40,  8'd8,   32'd3}, 1'b0, 3};
    vecs[1] = '{"mode2_pair",   '{2'd2, 32'h0000_2000, 32'h100, 8'd4,   32'd2}, 1'b0, 2};
    vecs[2] = '{"mode1_write",  '{2'd1, 32'h8000_0000, 32'h20,  8'd255, 32'd3}, 1'b0, 3};
    vecs[3] = '{"mode3_err",    '{2'd3, 32'h0000_3000, 32'h40,  8'd8,   32'd4}, 1'b1, 0};
    vecs[4] = '{"ntrans0",      '{2'd0, 32'h0000_4000, 32'h40,  8'd8,   32'd0}, 1'b0, 0};
    vecs[5] = '{"addr_wrap",    '{2'd0, 32'hFFFF_FFC0, 32'h40,  8'd16,  32'd2}, 1'b0, 2};
    vecs[6] = '{"mode2_single", '{2'd2, 32'h1234_5670, 32'h10,  8'd0,   32'd1}, 1'b0, 1};

    repeat (4) tick();
    check_all_zero("reset");
    rstn = 1'b1;
    repeat (2) tick();

    foreach (vecs[i])
      run_case(vecs[i].tag, vecs[i].cfg, vecs[i].exp_err, vecs[i].exp_cnt, 1'b0, -1, 1'b0);

    // Stop during the second WAIT of a long run: that transaction finishes.
    c = '{2'd0, 32'h0000_5000, 32'h80, 8'd8, 32'd10};
    run_case("abort_mode0", c, 1'b0, 2, 1'b1, 2, 1'b0);

    // Stop during a read half: the paired write still goes out.
    c = '{2'd2, 32'h0000_6000, 32'h80, 8'd2, 32'd5};
    run_case("abort_mode2", c, 1'b0, 1, 1'b1, 1, 1'b0);

    // Reset in the middle of WAIT clears everything and issues nothing more.
    c = '{2'd0, 32'hFFFF_FFC0, 32'h40, 8'd8, 32'd10};
    apply_cfg(c);
    got_q.delete();
    start = 1'b1;
    ok    = 1'b0;
    for (int cyc = 0; cyc < 50 && !ok; cyc++) begin
      tick();
      if (got_q.size() >= 1) ok = 1'b1;
    end
    check("rst_first_pulse_seen", ok, 1'b1);
    repeat (2) tick();
    rstn  = 1'b0;
    start = 1'b0;
    tick();
    check_all_zero("rst_midrun");
    n_seen = got_q.size();
    repeat (2) tick();
    rstn = 1'b1;
    repeat (20) tick();
    check("rst_no_more_pulses", got_q.size(), n_seen);
    check("rst_idle_after", {busy, done, err}, 3'b000);

    // Randomized runs with inputs scrambled mid-run and varied engine latency.
    for (int i = 0; i < 10; i++) begin
      c.mode   = 2'($urandom_range(0, 3));
      c.base   = $urandom;
      c.stride = $urandom;
      c.len    = 8'($urandom);
      c.ntrans = $urandom_range(0, 4);
      eng_lat  = $urandom_range(0, 7);
      run_case($sformatf("rand%0d", i), c, c.mode == 2'd3,
               (c.mode == 2'd3) ? 0 : int'(c.ntrans), 1'b0, -1, 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
